// File: rtl/fifo_rd_ctrl_if.sv
// Read-side control bus of the asynchronous FIFO.
//   rd_en            read request (requester -> controller)
//   rd_underflow_clr synchronous clear of the sticky underflow flag
//   wrptr_sync       Gray write pointer already synchronized into rd_clk
//   rd_accept        combinational RAM read strobe
//   rd_addr          registered RAM read address
//   rd_ptr_gray      registered Gray read pointer for the write domain
//   rd_empty, rd_almost_empty, rd_level, rd_underflow  registered status
// Modport master is the requester / surrounding FIFO; slave is fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  rd_en;
  logic                  rd_underflow_clr;
  logic [ADDR_WIDTH:0]   wrptr_sync;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  rd_empty;
  logic                  rd_almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  rd_underflow;

  modport master (
    output rd_en, rd_underflow_clr, wrptr_sync,
    input  rd_accept, rd_addr, rd_ptr_gray, rd_empty,
           rd_almost_empty, rd_level, rd_underflow
  );

  modport slave (
    input  rd_en, rd_underflow_clr, wrptr_sync,
    output rd_accept, rd_addr, rd_ptr_gray, rd_empty,
           rd_almost_empty, rd_level, rd_underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and status control of the asynchronous FIFO (rd_clk domain).
// Keeps the read pointer in binary and Gray form, drives the RAM read address,
// exports the Gray read pointer to the write domain and produces registered
// empty / almost-empty / level status plus a sticky underflow flag.
// Ports:
//   rd_clk    read-domain clock
//   rd_rst_n  asynchronous active-low reset
//   bus       fifo_rd_ctrl_if.slave (see interface header for signal list)
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic           rd_clk,
  input  logic           rd_rst_n,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int unsigned i = PW - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] level;
  logic          underflow;

  logic          accept;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;

  // Reads are only honoured against the registered empty flag, so a read
  // while empty leaves the pointer untouched.
  always_comb begin
    accept     = bus.rd_en & ~empty;
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, accept};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    wbin       = gray2bin(bus.wrptr_sync);
    // Modular difference: wrap bits make a full FIFO read as 2^ADDR_WIDTH.
    level_next = wbin - rbin_next;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      level        <= '0;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      // Full Gray compare: equal address with a different wrap bit is full, not empty.
      empty        <= (rgray_next == bus.wrptr_sync);
      almost_empty <= (level_next <= AE_THRESH);
      level        <= level_next;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      underflow <= 1'b0;
    end else if (bus.rd_en & empty) begin
      underflow <= 1'b1;
    end else if (bus.rd_underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  assign bus.rd_accept       = accept;
  assign bus.rd_addr         = rbin[ADDR_WIDTH-1:0];
  assign bus.rd_ptr_gray     = rgray;
  assign bus.rd_empty        = empty;
  assign bus.rd_almost_empty = almost_empty;
  assign bus.rd_level        = level;
  assign bus.rd_underflow    = underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int PMOD   = 32;
  localparam int THRESH = 2;

  logic clk;
  logic rst_n;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(THRESH)) dut (
    .rd_clk  (clk),
    .rd_rst_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] gray;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  bit   acc_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: counts of words written (visible via wrptr_sync) and read.
  int  m_wr;
  int  m_rd;
  bit  m_empty;
  bit  m_uf;
  logic [4:0] prev_gray;

  function automatic logic [4:0] to_gray(input int n);
    int b;
    b = n % PMOD;
    return 5'((b >> 1) ^ b);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr      = 0;
    m_rd      = 0;
    m_empty   = 1'b1;
    m_uf      = 1'b0;
    prev_gray = '0;
  endtask

  // One rd_clk cycle of stimulus; the expected response goes to the scoreboard.
  task automatic cycle(input bit en, input bit clr, input int w_adv);
    exp_t e;
    bit   acc;
    int   lvl;
    @(negedge clk);
    m_wr = m_wr + w_adv;
    bus.rd_en            = en;
    bus.rd_underflow_clr = clr;
    bus.wrptr_sync       = to_gray(m_wr);
    acc = en && !m_empty;
    acc_q.push_back(acc);
    if (en && m_empty) m_uf = 1'b1;
    else if (clr)      m_uf = 1'b0;
    if (acc) m_rd++;
    lvl = m_wr - m_rd;
    m_empty = (lvl == 0);
    e.addr  = 4'(m_rd % DEPTH);
    e.gray  = to_gray(m_rd);
    e.empty = m_empty;
    e.ae    = (lvl <= THRESH);
    e.level = 5'(lvl);
    e.uf    = m_uf;
    exp_q.push_back(e);
  endtask

  // Combinational strobe is sampled mid-cycle, after the inputs settle.
  always @(negedge clk) begin
    #2;
    if (acc_q.size() > 0) check("rd_accept", int'(bus.rd_accept), int'(acc_q.pop_front()));
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_addr", int'(bus.rd_addr), int'(e.addr));
      check("rd_ptr_gray", int'(bus.rd_ptr_gray), int'(e.gray));
      check("rd_empty", int'(bus.rd_empty), int'(e.empty));
      check("rd_almost_empty", int'(bus.rd_almost_empty), int'(e.ae));
      check("rd_level", int'(bus.rd_level), int'(e.level));
      check("rd_underflow", int'(bus.rd_underflow), int'(e.uf));
      check("gray_one_bit_step", $countones(bus.rd_ptr_gray ^ prev_gray) <= 1 ? 1 : 0, 1);
      prev_gray = bus.rd_ptr_gray;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check({tag, "_rd_ptr_gray"}, int'(bus.rd_ptr_gray), 0);
    check({tag, "_rd_empty"}, int'(bus.rd_empty), 1);
    check({tag, "_rd_almost_empty"}, int'(bus.rd_almost_empty), 1);
    check({tag, "_rd_level"}, int'(bus.rd_level), 0);
    check({tag, "_rd_underflow"}, int'(bus.rd_underflow), 0);
    check({tag, "_rd_accept"}, int'(bus.rd_accept), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, held for two edges, released at negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    bus.rd_en            = 1'b0;
    bus.rd_underflow_clr = 1'b0;
    bus.wrptr_sync       = '0;
    rst_n = 1'b0;
    #1;
    check_reset_values({tag, "_async"});
    @(negedge clk);
    @(negedge clk);
    check_reset_values({tag, "_held"});
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int adv;
    bus.rd_en            = 1'b0;
    bus.rd_underflow_clr = 1'b0;
    bus.wrptr_sync       = '0;
    rst_n = 1'b1;
    model_reset();
    #1;
    do_reset("por");

    // Read attempts while empty set underflow; clear drops it.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(1, 1, 0);   // set wins over clear
    cycle(0, 1, 0);

    // Three words then three reads.
    cycle(0, 0, 3);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("three_reads_gray", int'(bus.rd_ptr_gray), 5'b00010);
    check("three_reads_addr", int'(bus.rd_addr), 3);

    // Full FIFO from reset, drained to empty.
    do_reset("pre_full");
    cycle(0, 0, 16);
    cycle(0, 0, 0);
    check("full_level", int'(bus.rd_level), 16);
    check("full_empty", int'(bus.rd_empty), 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("drained_gray", int'(bus.rd_ptr_gray), 5'b11000);
    check("drained_addr", int'(bus.rd_addr), 0);
    check("drained_empty", int'(bus.rd_empty), 1);

    // Streaming across the pointer wrap with the writer four ahead.
    cycle(0, 0, 4);
    for (int i = 0; i < 40; i++) cycle(1, 0, 1);

    // Last word read while the write pointer advances.
    cycle(0, 0, 0);
    while (m_wr - m_rd > 1) cycle(1, 0, 0);
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    check("simul_empty", int'(bus.rd_empty), 0);
    check("simul_level", int'(bus.rd_level), 1);

    // Reset mid-stream at level 7, then resume from pointer 0.
    cycle(0, 0, 7 - (m_wr - m_rd));
    cycle(1, 0, 0);
    do_reset("mid");
    cycle(0, 0, 5);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);

    // Randomized traffic; writer never exceeds the depth ahead of the reader.
    for (int i = 0; i < 400; i++) begin
      adv = int'($urandom_range(0, 2));
      if (m_wr + adv - m_rd > DEPTH) adv = 0;
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), adv);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side control for the asynchronous FIFO, in the rd_clk domain directly downstream of the write-pointer synchronizer. It consumes the synchronized Gray write pointer and maintains the read pointer in binary and Gray form. It drives the RAM read address and the Gray read pointer that is sent to the write domain. It also produces registered empty, almost-empty, occupancy-level and sticky underflow status.

## Interface
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AEMPTY_THRESH, 2, rd_almost_empty asserts when level <= this value; legal range 0..2^ADDR_WIDTH.

- rd_clk  in  1  read-domain clock.
- rd_rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_underflow_clr  in  1  synchronous clear of rd_underflow.
- wrptr_sync  in  ADDR_WIDTH+1  Gray write pointer, already synchronized to rd_clk.
- rd_accept  out  1  combinational, = rd_en & ~rd_empty; RAM read strobe.
- rd_addr  out  ADDR_WIDTH  RAM read address, = low ADDR_WIDTH bits of the binary read pointer (registered).
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
- rd_empty  out  1  registered empty flag.
- rd_almost_empty  out  1  registered, level <= AEMPTY_THRESH.
- rd_level  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH.
- rd_underflow  out  1  sticky: a read was attempted while empty.

## Operation
- State registers: rbin and rgray (both ADDR_WIDTH+1 bits), rd_empty, rd_almost_empty, rd_level, rd_underflow.
- rbin_next = rbin + rd_accept, computed modulo 2^(ADDR_WIDTH+1). Wrap from all-ones to 0 is natural.
- rgray_next = (rbin_next >> 1) ^ rbin_next. rgray is the only value exported to the other domain; it changes by at most one bit per cycle.
- Empty: rd_empty <= (rgray_next == wrptr_sync). The full Gray values are compared, so an equal address with a differing wrap bit is not empty.
- Level:
  - wbin = Gray-to-binary(wrptr_sync), computed combinationally.
  - rd_level <= (wbin − rbin_next) modulo 2^(ADDR_WIDTH+1).
  - rd_almost_empty <= (wbin − rbin_next) <= AEMPTY_THRESH.
- Underflow:
  - rd_underflow sets on any cycle with rd_en & rd_empty.
  - It clears on rd_underflow_clr.
  - If set and clear occur in the same cycle, set wins.
- A read while empty is ignored: the pointer does not move and rd_accept = 0.
- Full (level = 2^ADDR_WIDTH) is legal input. Level beyond 2^ADDR_WIDTH cannot occur with a correct write side and needs no handling.
- Flags are conservative because wrptr_sync lags the true write pointer. Empty may be pessimistic, but a non-empty FIFO is never reported as empty-then-read past.

## Timing
- Reset (asynchronous assert, synchronous to rd_clk on release): rbin=0, rgray=0, rd_addr=0, rd_ptr_gray=0, rd_empty=1, rd_almost_empty=1, rd_level=0, rd_underflow=0.
- Read accepted in cycle N: RAM data at the old rd_addr is consumed in cycle N. rd_addr, rd_ptr_gray, rd_empty and rd_level update at the edge ending cycle N.
- wrptr_sync change in cycle N: rd_empty, rd_level and rd_almost_empty reflect it after the edge ending cycle N (1 rd_clk latency, in addition to the synchronizer's 2).
- Reading the last word while wrptr_sync advances in the same cycle: the flags use the new wrptr_sync and rbin_next together; no false empty and no missed word.
- Reset mid-operation: all state returns to reset values immediately. The write domain observes rd_ptr_gray=0, and is reset together with this block.

## Test plan
- Reset, then hold rd_en=1 with wrptr_sync=0 -> rd_accept=0, rd_addr stays 0, rd_empty=1, rd_underflow=1 one cycle later. Pulse rd_underflow_clr -> rd_underflow=0 next cycle.
- wrptr_sync=5'b00010 (binary 3) -> next cycle rd_empty=0, rd_level=3, rd_almost_empty=0. Three back-to-back reads -> rd_addr 0,1,2 then 3; rd_level 2,1,0; rd_almost_empty=1 after the first read; rd_empty=1 after the third; rd_ptr_gray=5'b00010.
- Full: from reset, set wrptr_sync=5'b11000 (binary 16) -> rd_level=16, rd_empty=0. Read 16 words -> rd_addr wraps 15->0, rd_ptr_gray=5'b11000, rd_empty=1.
- Wrap: stream 40 words with wrptr_sync leading by 4 -> rbin passes 31->0, rd_ptr_gray changes one bit per read, rd_level stays 3-4, and rd_empty is never asserted while the level is nonzero.
- Simultaneous: rd_level=1, read the last word in the same cycle wrptr_sync advances by 1 -> rd_empty stays 0, rd_level=1.
- Assert rd_rst_n low mid-stream at rd_level=7 -> all outputs take reset values while reset is held; after release, operation resumes cleanly from pointer 0.
